// File: rtl/udp_rx_pkg.sv
// rtl/udp_rx_pkg.sv - shared types, header default and width helpers for the UDP video unpacker
package udp_rx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_e;

  localparam logic [31:0] FRAME_HEAD_DEF = 32'hF3ED7A93;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  function automatic int lane_bits(input int pix_bytes);
    return clog2_min1(pix_bytes);
  endfunction

  function automatic int pix_x_bits(input int h_active);
    return clog2_min1(h_active);
  endfunction

endpackage

// File: rtl/udp_rx_head_det.sv
// rtl/udp_rx_head_det.sv - 32-bit header matcher over the incoming byte stream
module udp_rx_head_det
  import udp_rx_pkg::*;
#(
  parameter logic [31:0] HEAD = FRAME_HEAD_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic [7:0] byte_i,
  output logic       match_o
);

  // Only the three previous bytes need storing; the fourth is the live input.
  logic [23:0] sr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_q <= '0;
    end else if (clr_i) begin
      sr_q <= '0;
    end else if (en_i) begin
      sr_q <= {sr_q[15:0], byte_i};
    end
  end

  assign match_o = en_i && ({sr_q, byte_i} == HEAD);

endmodule

// File: rtl/udp_rx_vid_unpack.sv
// rtl/udp_rx_vid_unpack.sv - header hunt, pixel packing, line tracking and frame status
module udp_rx_vid_unpack
  import udp_rx_pkg::*;
#(
  parameter logic [31:0] FRAME_HEAD  = FRAME_HEAD_DEF,
  parameter int          PIX_BYTES   = 2,
  parameter int          H_ACTIVE    = 1280,
  parameter int          TIMEOUT_CYC = 4096
) (
  input  logic                   rstn,
  input  logic                   app_rx_clk,
  input  logic                   app_rx_data_valid,
  input  logic [7:0]             app_rx_data,
  input  logic [24:0]            app_rx_data_total,
  output logic                   vid_vs,
  output logic                   vid_hs,
  output logic                   vid_de,
  output logic [PIX_BYTES*8-1:0] vid_data,
  output logic [15:0]            vid_line,
  output logic                   frame_done,
  output logic                   frame_err
);

  localparam int PW = PIX_BYTES * 8;
  localparam int LW = lane_bits(PIX_BYTES);
  localparam int XW = pix_x_bits(H_ACTIVE);
  localparam int IW = clog2_min1(TIMEOUT_CYC);
  localparam logic [LW-1:0] LANE_LAST = LW'(PIX_BYTES - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(H_ACTIVE - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYC - 1);

  rx_state_e     state_q, state_d;
  logic [24:0]   total_q, total_d;
  logic [24:0]   byte_cnt_q, byte_cnt_d;
  logic [PW-1:0] pix_sr_q, pix_sr_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [XW-1:0] pix_x_q, pix_x_d;
  logic [15:0]   line_q, line_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic          vs_q, vs_d, hs_q, hs_d, de_q, de_d;
  logic          done_q, done_d, err_q, err_d;
  logic [PW-1:0] data_q, data_d;
  logic [15:0]   vid_line_q, vid_line_d;

  logic          head_match;
  logic [PW-1:0] pix_next;

  udp_rx_head_det #(.HEAD(FRAME_HEAD)) u_head_det (
    .clk     (app_rx_clk),
    .rstn    (rstn),
    .en_i    (app_rx_data_valid && (state_q == IDLE)),
    .clr_i   (head_match),
    .byte_i  (app_rx_data),
    .match_o (head_match)
  );

  // Newest byte lands in the LSBs so the first byte of a pixel ends up in the MSBs.
  assign pix_next = PW'({pix_sr_q, app_rx_data});

  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    byte_cnt_d = byte_cnt_q;
    pix_sr_d   = pix_sr_q;
    lane_d     = lane_q;
    pix_x_d    = pix_x_q;
    line_d     = line_q;
    idle_cnt_d = idle_cnt_q;
    vid_line_d = vid_line_q;
    vs_d       = 1'b0;
    hs_d       = 1'b0;
    de_d       = 1'b0;
    data_d     = '0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (head_match) begin
          total_d    = app_rx_data_total;
          byte_cnt_d = '0;
          pix_sr_d   = '0;
          lane_d     = '0;
          pix_x_d    = '0;
          line_d     = '0;
          idle_cnt_d = '0;
          vs_d       = 1'b1;
          if (app_rx_data_total == 25'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = RECV;
          end
        end
      end
      RECV: begin
        if (app_rx_data_valid) begin
          idle_cnt_d = '0;
          pix_sr_d   = pix_next;
          byte_cnt_d = byte_cnt_q + 25'd1;
          if (lane_q == LANE_LAST) begin
            lane_d     = '0;
            de_d       = 1'b1;
            data_d     = pix_next;
            hs_d       = (pix_x_q == '0);
            vid_line_d = line_q;
            if (pix_x_q == X_LAST) begin
              pix_x_d = '0;
              line_d  = line_q + 16'd1;
            end else begin
              pix_x_d = pix_x_q + XW'(1);
            end
          end else begin
            lane_d = lane_q + LW'(1);
          end
          if (byte_cnt_q == total_q - 25'd1) begin
            state_d = IDLE;
            if (lane_q == LANE_LAST) begin
              done_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end else if (idle_cnt_q == IDLE_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge app_rx_clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      total_q    <= '0;
      byte_cnt_q <= '0;
      pix_sr_q   <= '0;
      lane_q     <= '0;
      pix_x_q    <= '0;
      line_q     <= '0;
      idle_cnt_q <= '0;
      vid_line_q <= '0;
      vs_q       <= 1'b0;
      hs_q       <= 1'b0;
      de_q       <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      byte_cnt_q <= byte_cnt_d;
      pix_sr_q   <= pix_sr_d;
      lane_q     <= lane_d;
      pix_x_q    <= pix_x_d;
      line_q     <= line_d;
      idle_cnt_q <= idle_cnt_d;
      vid_line_q <= vid_line_d;
      vs_q       <= vs_d;
      hs_q       <= hs_d;
      de_q       <= de_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign vid_vs     = vs_q;
  assign vid_hs     = hs_q;
  assign vid_de     = de_q;
  assign vid_data   = data_q;
  assign vid_line   = vid_line_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_udp_rx_vid_unpack.sv
// tb/tb_udp_rx_vid_unpack.sv - bench for udp_rx_vid_unpack at 2- and 3-byte pixel widths
module tb_udp_rx_vid_unpack;

  localparam logic [31:0] HEAD = 32'hF3ED7A93;
  localparam int TMO  = 16;
  localparam int MAXC = 2048;

  typedef struct {
    int tot;
    int nb;
    int first;
    int gap;
    bit hdrpay;
    int npx2;
    int end2;
    int npx3;
    int end3;
  } vec_t;

  vec_t vecs[6];

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid;
  logic [7:0]  din;
  logic [24:0] total;

  always #4 clk = ~clk;

  logic        vs2, hs2, de2, done2, err2;
  logic [15:0] data2, line2;
  logic        vs3, hs3, de3, done3, err3;
  logic [23:0] data3;
  logic [15:0] line3;

  udp_rx_vid_unpack #(.PIX_BYTES(2), .H_ACTIVE(4), .TIMEOUT_CYC(TMO)) dut2 (
    .rstn(rstn), .app_rx_clk(clk), .app_rx_data_valid(valid), .app_rx_data(din),
    .app_rx_data_total(total), .vid_vs(vs2), .vid_hs(hs2), .vid_de(de2), .vid_data(data2),
    .vid_line(line2), .frame_done(done2), .frame_err(err2)
  );

  udp_rx_vid_unpack #(.PIX_BYTES(3), .H_ACTIVE(3), .TIMEOUT_CYC(TMO)) dut3 (
    .rstn(rstn), .app_rx_clk(clk), .app_rx_data_valid(valid), .app_rx_data(din),
    .app_rx_data_total(total), .vid_vs(vs3), .vid_hs(hs3), .vid_de(de3), .vid_data(data3),
    .vid_line(line3), .frame_done(done3), .frame_err(err3)
  );

  logic        o_vs[2], o_hs[2], o_de[2], o_done[2], o_err[2];
  logic [31:0] o_data[2];
  logic [15:0] o_line[2];
  assign o_vs[0] = vs2;   assign o_vs[1] = vs3;
  assign o_hs[0] = hs2;   assign o_hs[1] = hs3;
  assign o_de[0] = de2;   assign o_de[1] = de3;
  assign o_done[0] = done2; assign o_done[1] = done3;
  assign o_err[0] = err2; assign o_err[1] = err3;
  assign o_data[0] = {16'h0, data2};
  assign o_data[1] = {8'h0, data3};
  assign o_line[0] = line2; assign o_line[1] = line3;

  bit          s_v[MAXC];
  logic [7:0]  s_d[MAXC];
  bit          s_r[MAXC];
  int          n_stim;

  bit          e_vs[2][MAXC], e_hs[2][MAXC], e_de[2][MAXC], e_done[2][MAXC], e_err[2][MAXC];
  logic [31:0] e_data[2][MAXC];
  logic [15:0] e_line[2][MAXC];
  logic [31:0] m_win[2];

  int n_chk, n_pass;
  int c_vs[2], c_de[2], c_done[2], c_err[2];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic add(input bit v, input logic [7:0] d, input bit r);
    if (n_stim < MAXC) begin
      s_v[n_stim] = v;
      s_d[n_stim] = d;
      s_r[n_stim] = r;
      n_stim++;
    end
  endtask

  function automatic int gap_of(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return ($urandom_range(0, 15) == 0) ? 18 : int'($urandom_range(0, 2));
  endfunction

  task automatic add_byte(input logic [7:0] b, input int mode);
    int g;
    g = gap_of(mode);
    add(1'b1, b, 1'b0);
    repeat (g) add(1'b0, 8'h00, 1'b0);
  endtask

  // Junk F3 F3 ED precedes the real header so a partial match must be abandoned.
  task automatic add_header(input int mode);
    logic [7:0] hb[7];
    hb = '{8'hF3, 8'hF3, 8'hED, 8'hF3, 8'hED, 8'h7A, 8'h93};
    for (int i = 0; i < 7; i++) add_byte(hb[i], mode);
  endtask

  // Frame-level reference: find the header in the byte stream, then number payload bytes
  // and derive pixel index, line and frame outcome arithmetically.
  task automatic model(input int k, input int pb, input int h, input int tot);
    bit          in_frame;
    int          run, m, px;
    logic [31:0] w, pix;
    logic [7:0]  pay[$];
    in_frame = 1'b0;
    run = 0;
    for (int c = 0; c < n_stim; c++) begin
      e_vs[k][c] = 0; e_hs[k][c] = 0; e_de[k][c] = 0; e_done[k][c] = 0; e_err[k][c] = 0;
      e_data[k][c] = '0; e_line[k][c] = '0;
    end
    for (int c = 0; c < n_stim; c++) begin
      if (s_r[c]) begin
        m_win[k] = '0;
        in_frame = 1'b0;
        pay.delete();
      end else if (!in_frame) begin
        if (s_v[c]) begin
          w = {m_win[k][23:0], s_d[c]};
          if (w == HEAD) begin
            m_win[k] = '0;
            e_vs[k][c] = 1;
            if (tot == 0) e_done[k][c] = 1;
            else begin
              in_frame = 1'b1;
              run = 0;
              pay.delete();
            end
          end else begin
            m_win[k] = w;
          end
        end
      end else if (s_v[c]) begin
        run = 0;
        pay.push_back(s_d[c]);
        m = pay.size();
        if (m % pb == 0) begin
          px = m / pb - 1;
          pix = '0;
          for (int j = 0; j < pb; j++) pix = (pix << 8) | {24'h0, pay[m - pb + j]};
          e_de[k][c]   = 1;
          e_data[k][c] = pix;
          e_hs[k][c]   = (px % h == 0);
          e_line[k][c] = 16'((px / h) % 65536);
        end
        if (m == tot) begin
          if (m % pb == 0) e_done[k][c] = 1;
          else e_err[k][c] = 1;
          in_frame = 1'b0;
        end
      end else begin
        run++;
        if (run == TMO) begin
          e_err[k][c] = 1;
          in_frame = 1'b0;
        end
      end
    end
  endtask

  task automatic check_zero(input int sid);
    for (int k = 0; k < 2; k++)
      check($sformatf("s%0d dut%0d outputs zero in reset", sid, k + 2),
            {11'h0, o_vs[k], o_hs[k], o_de[k], o_done[k], o_err[k], o_data[k], o_line[k]},
            64'h0);
  endtask

  task automatic cmp(input int k, input int c, input int sid);
    check($sformatf("s%0d dut%0d cyc%0d vs/hs/de/done/err/data", sid, k + 2, c),
          {27'h0, o_vs[k], o_hs[k], o_de[k], o_done[k], o_err[k], o_data[k]},
          {27'h0, e_vs[k][c], e_hs[k][c], e_de[k][c], e_done[k][c], e_err[k][c], e_data[k][c]});
    if (e_de[k][c])
      check($sformatf("s%0d dut%0d cyc%0d vid_line", sid, k + 2, c),
            {48'h0, o_line[k]}, {48'h0, e_line[k][c]});
    c_vs[k]   += int'(o_vs[k]);
    c_de[k]   += int'(o_de[k]);
    c_done[k] += int'(o_done[k]);
    c_err[k]  += int'(o_err[k]);
  endtask

  task automatic run_stim(input int tot, input int sid);
    model(0, 2, 4, tot);
    model(1, 3, 3, tot);
    total = 25'(tot);
    for (int k = 0; k < 2; k++) begin
      c_vs[k] = 0; c_de[k] = 0; c_done[k] = 0; c_err[k] = 0;
    end
    for (int c = 0; c < n_stim; c++) begin
      valid = s_v[c];
      din   = s_d[c];
      if (s_r[c]) begin
        if (rstn) begin
          rstn = 1'b0;
          #1;
          check_zero(sid);
        end
      end else begin
        rstn = 1'b1;
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) cmp(k, c, sid);
    end
  endtask

  task automatic check_counts(input int sid, input int k, input int nvs, input int npx, input int nd, input int ne);
    check($sformatf("s%0d dut%0d vs count", sid, k + 2), 64'(c_vs[k]), 64'(nvs));
    check($sformatf("s%0d dut%0d de count", sid, k + 2), 64'(c_de[k]), 64'(npx));
    check($sformatf("s%0d dut%0d done count", sid, k + 2), 64'(c_done[k]), 64'(nd));
    check($sformatf("s%0d dut%0d err count", sid, k + 2), 64'(c_err[k]), 64'(ne));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int tot, nb, sel;
    logic [31:0] hw;
    // tot, nbytes, first, gap mode, header-pattern payload, px2, end2, px3, end3 (1=done 2=err)
    vecs[0] = '{16, 16, 8'h00, 0, 1'b0, 8, 1, 5, 2};
    vecs[1] = '{7,  7,  8'h11, 0, 1'b0, 3, 2, 2, 2};
    vecs[2] = '{0,  0,  8'h00, 0, 1'b0, 0, 1, 0, 1};
    vecs[3] = '{12, 12, 8'h40, 1, 1'b0, 6, 1, 4, 1};
    vecs[4] = '{100, 5, 8'h20, 0, 1'b0, 2, 2, 1, 2};
    vecs[5] = '{8,  8,  8'h00, 0, 1'b1, 4, 1, 2, 2};

    n_chk = 0; n_pass = 0;
    m_win[0] = '0; m_win[1] = '0;
    rstn = 1'b0; valid = 1'b0; din = 8'h00; total = '0;
    repeat (3) @(negedge clk);
    check_zero(0);
    rstn = 1'b1;

    hw = HEAD;
    for (int i = 0; i < 6; i++) begin
      n_stim = 0;
      add_header(vecs[i].gap);
      for (int j = 0; j < vecs[i].nb; j++)
        add_byte(vecs[i].hdrpay ? 8'(hw >> (8 * (3 - j % 4))) : 8'(vecs[i].first + j), vecs[i].gap);
      repeat (24) add(1'b0, 8'h00, 1'b0);
      run_stim(vecs[i].tot, i + 1);
      check_counts(i + 1, 0, 1, vecs[i].npx2, int'(vecs[i].end2 == 1), int'(vecs[i].end2 == 2));
      check_counts(i + 1, 1, 1, vecs[i].npx3, int'(vecs[i].end3 == 1), int'(vecs[i].end3 == 2));
    end

    // Reset lands right after the third 2-byte pixel; the next frame must still be found.
    n_stim = 0;
    add_header(0);
    for (int j = 0; j < 6; j++) add_byte(8'(8'h50 + j), 0);
    add(1'b0, 8'h00, 1'b1);
    add(1'b0, 8'h00, 1'b1);
    repeat (20) add(1'b0, 8'h00, 1'b0);
    add_header(0);
    for (int j = 0; j < 16; j++) add_byte(8'(8'h60 + j), 0);
    repeat (24) add(1'b0, 8'h00, 1'b0);
    run_stim(16, 7);
    check_counts(7, 0, 2, 11, 1, 0);
    check_counts(7, 1, 2, 7, 0, 1);

    for (int r = 0; r < 30; r++) begin
      n_stim = 0;
      tot = int'($urandom_range(0, 30));
      sel = int'($urandom_range(0, 2));
      nb = (sel == 0) ? tot : (sel == 1) ? int'($urandom_range(0, tot)) : tot + int'($urandom_range(1, 3));
      add_header(2);
      for (int j = 0; j < nb; j++) add_byte(8'($urandom_range(0, 255)), 2);
      repeat (24) add(1'b0, 8'h00, 1'b0);
      run_stim(tot, 100 + r);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
